// File: rtl/compound_peer.sv
// compound_peer: request/response initiator issuing NUM_TXN transactions, one outstanding at a time.
// Latency: a request is offered the cycle after start/previous response; each handshake takes >= 1 cycle.
// Backpressure: req_out is held stable with notify high until req_out_sync; responses are accepted only in WAIT_RSP.
//
// Ports:
//   clk, rst (async active-low)  - clock and reset
//   start                        - begin a run (ignored while busy)
//   req_out / req_out_notify / req_out_sync - request channel (notify = valid, sync = ready)
//   rsp_in / rsp_in_sync / rsp_in_notify    - response channel (sync = valid, notify = ready)
//   busy, done                   - run status
//   txn_count, err_count         - completed transactions / response mismatches (saturating)
//   last_rsp                     - most recently captured response
// Optional feature macro: COMPOUND_PEER_CHECK_EN enables response checking into err_count.

package compound_peer_pkg;
  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_t;
endpackage

module compound_peer
  import compound_peer_pkg::*;
#(
  parameter int unsigned        NUM_TXN  = 16,
  parameter logic signed [31:0] X_START  = 32'sd0,
  parameter logic signed [31:0] X_OFFSET = 32'sd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output compound_t   req_out,
  input  logic        req_out_sync,
  output logic        req_out_notify,
  input  compound_t   rsp_in,
  input  logic        rsp_in_sync,
  output logic        rsp_in_notify,
  output logic        busy,
  output logic        done,
  output logic [15:0] txn_count,
  output logic [15:0] err_count,
  output compound_t   last_rsp
);

  localparam logic [15:0] NUM_TXN_W = NUM_TXN[15:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  compound_t   r_req;
  compound_t   w_req_nxt;
  compound_t   r_last_rsp;
  compound_t   w_last_nxt;
  logic [15:0] r_txn_count;
  logic [15:0] w_txn_nxt;
  logic [15:0] w_txn_inc;
  logic        r_req_notify;
  logic        r_rsp_notify;
  logic        r_busy;
  logic        r_done;
  logic        w_req_xfer;
  logic        w_rsp_xfer;
  logic        w_clr_err;
  logic signed [31:0] w_x_inc;

  // Notify registers are high exactly while in the owning state, so they
  // double as the state qualifiers for the handshakes.
  assign w_req_xfer = r_req_notify & req_out_sync;
  assign w_rsp_xfer = r_rsp_notify & rsp_in_sync;

  assign w_txn_inc = (r_txn_count == 16'hFFFF) ? r_txn_count : r_txn_count + 16'd1;
  assign w_x_inc   = r_req.x + 32'sd1;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_last_nxt  = r_last_rsp;
    w_txn_nxt   = r_txn_count;
    w_clr_err   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_txn_nxt      = 16'd0;
          w_clr_err      = 1'b1;
          w_req_nxt.mode = MODE_WRITE;
          w_req_nxt.x    = X_START;
          w_req_nxt.y    = X_START[0];
          w_state_nxt    = (NUM_TXN == 0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (w_req_xfer) begin
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (w_rsp_xfer) begin
          w_last_nxt = rsp_in;
          w_txn_nxt  = w_txn_inc;
          if (w_txn_inc == NUM_TXN_W) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt    = SEND;
            w_req_nxt.x    = w_x_inc;
            w_req_nxt.y    = w_x_inc[0];
            w_req_nxt.mode = (r_req.mode == MODE_WRITE) ? MODE_READ : MODE_WRITE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req        <= '{mode: MODE_READ, x: 32'sd0, y: 1'b0};
      r_last_rsp   <= '{mode: MODE_READ, x: 32'sd0, y: 1'b0};
      r_txn_count  <= 16'd0;
      r_req_notify <= 1'b0;
      r_rsp_notify <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_last_rsp   <= w_last_nxt;
      r_txn_count  <= w_txn_nxt;
      r_req_notify <= (w_state_nxt == SEND);
      r_rsp_notify <= (w_state_nxt == WAIT_RSP);
      r_busy       <= (w_state_nxt == SEND) || (w_state_nxt == WAIT_RSP);
      r_done       <= (w_state_nxt == DONE);
    end
  end

`ifdef COMPOUND_PEER_CHECK_EN
  logic [15:0]        r_err_count;
  logic signed [31:0] w_exp_x;
  logic               w_rsp_bad;

  // r_req still holds the outstanding request while in WAIT_RSP.
  assign w_exp_x   = r_req.x + X_OFFSET;
  assign w_rsp_bad = (rsp_in.x != w_exp_x) || (rsp_in.mode != r_req.mode) ||
                     (rsp_in.y != rsp_in.x[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= 16'd0;
    end else if (w_clr_err) begin
      r_err_count <= 16'd0;
    end else if (w_rsp_xfer && w_rsp_bad && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused;
  assign w_unused  = ^{X_OFFSET, w_clr_err};
  assign err_count = 16'd0;
`endif

  assign req_out        = r_req;
  assign req_out_notify = r_req_notify;
  assign rsp_in_notify  = r_rsp_notify;
  assign busy           = r_busy;
  assign done           = r_done;
  assign txn_count      = r_txn_count;
  assign last_rsp       = r_last_rsp;

endmodule

// File: tb/tb_compound_peer.sv
`timescale 1ns/1ps
module tb_compound_peer;
  import compound_peer_pkg::*;

`ifdef COMPOUND_PEER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NA = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: NUM_TXN=4, X_START=0 (main function, random handshakes, reset)
  logic a_start, a_req_sync, a_rsp_sync, a_req_notify, a_rsp_notify, a_busy, a_done;
  compound_t a_req, a_rsp, a_last;
  logic [15:0] a_txn, a_err;
  // Instance B: wrap-around of x with a loopback responder
  logic b_start, b_req_sync, b_rsp_sync, b_req_notify, b_rsp_notify, b_busy, b_done;
  compound_t b_req, b_rsp, b_last;
  logic [15:0] b_txn, b_err;
  logic signed [31:0] b_rx;
  // Instance C: NUM_TXN=0
  logic c_start, c_req_sync, c_rsp_sync, c_req_notify, c_rsp_notify, c_busy, c_done;
  compound_t c_req, c_rsp, c_last;
  logic [15:0] c_txn, c_err;

  compound_peer #(.NUM_TXN(4), .X_START(32'sd0), .X_OFFSET(32'sd1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .req_out(a_req), .req_out_sync(a_req_sync),
    .req_out_notify(a_req_notify), .rsp_in(a_rsp), .rsp_in_sync(a_rsp_sync),
    .rsp_in_notify(a_rsp_notify), .busy(a_busy), .done(a_done), .txn_count(a_txn),
    .err_count(a_err), .last_rsp(a_last));

  compound_peer #(.NUM_TXN(2), .X_START(32'h7FFFFFFF), .X_OFFSET(32'sd1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .req_out(b_req), .req_out_sync(b_req_sync),
    .req_out_notify(b_req_notify), .rsp_in(b_rsp), .rsp_in_sync(b_rsp_sync),
    .rsp_in_notify(b_rsp_notify), .busy(b_busy), .done(b_done), .txn_count(b_txn),
    .err_count(b_err), .last_rsp(b_last));

  compound_peer #(.NUM_TXN(0), .X_START(32'sd5), .X_OFFSET(32'sd1)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .req_out(c_req), .req_out_sync(c_req_sync),
    .req_out_notify(c_req_notify), .rsp_in(c_rsp), .rsp_in_sync(c_rsp_sync),
    .rsp_in_notify(c_rsp_notify), .busy(c_busy), .done(c_done), .txn_count(c_txn),
    .err_count(c_err), .last_rsp(c_last));

  assign b_rx  = b_req.x + 32'sd1;
  assign b_rsp = '{mode: b_req.mode, x: b_rx, y: b_rx[0]};

  // Request k of a run: x counts up from the start value, modes alternate starting with write.
  function automatic compound_t exp_req(input logic signed [31:0] xs, input int k);
    compound_t r;
    logic signed [31:0] x;
    x = xs + k;
    r.mode = (k % 2 == 0) ? MODE_WRITE : MODE_READ;
    r.x = x;
    r.y = x[0];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    a_start = 0; a_req_sync = 0; a_rsp_sync = 0; a_rsp = '0;
    b_start = 0; b_req_sync = 1; b_rsp_sync = 1;
    c_start = 0; c_req_sync = 1; c_rsp_sync = 1; c_rsp = '0;
    #12;
    vectors++; if (a_req !== 34'h0) begin miscompares++; $display("FAIL reset_req_out: got %h want %h", a_req, 34'h0); end
    vectors++; if (a_last !== 34'h0) begin miscompares++; $display("FAIL reset_last_rsp: got %h want %h", a_last, 34'h0); end
    vectors++; if ({a_req_notify, a_rsp_notify, a_busy, a_done} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {a_req_notify, a_rsp_notify, a_busy, a_done}); end
    vectors++; if ({a_txn, a_err} !== 32'h0) begin miscompares++; $display("FAIL reset_counts: got %h want 0", {a_txn, a_err}); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({a_req_notify, a_busy, a_done} !== 3'b0) begin miscompares++; $display("FAIL idle_after_reset: got %b want 000", {a_req_notify, a_busy, a_done}); end
  endtask

  task automatic test_num_txn_zero();
    @(negedge clk); c_start = 1;
    @(negedge clk); c_start = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (c_done !== 1'b1) begin miscompares++; $display("FAIL zero_done[%0d]: got %b want 1", i, c_done); end
      vectors++; if ({c_req_notify, c_rsp_notify, c_busy} !== 3'b0) begin miscompares++; $display("FAIL zero_notify[%0d]: got %b want 000", i, {c_req_notify, c_rsp_notify, c_busy}); end
      vectors++; if (c_txn !== 16'd0) begin miscompares++; $display("FAIL zero_txn[%0d]: got %0d want 0", i, c_txn); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    compound_t got[2];
    int seen = 0;
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    for (int cyc = 0; cyc < 20 && !b_done; cyc++) begin
      if (b_req_notify && seen < 2) begin got[seen] = b_req; seen++; end
      @(negedge clk);
    end
    vectors++; if (seen !== 2) begin miscompares++; $display("FAIL wrap_req_count: got %0d want 2", seen); end
    if (seen == 2) begin
      vectors++; if (got[0] !== exp_req(32'h7FFFFFFF, 0)) begin miscompares++; $display("FAIL wrap_req0: got %h want %h", got[0], exp_req(32'h7FFFFFFF, 0)); end
      vectors++; if (got[1].x !== 32'h80000000 || got[1].y !== 1'b0 || got[1].mode !== MODE_READ) begin miscompares++; $display("FAIL wrap_req1: got %h want x=80000000 y=0 read", got[1]); end
    end
    vectors++; if (b_done !== 1'b1 || b_txn !== 16'd2) begin miscompares++; $display("FAIL wrap_done: got done=%b txn=%0d want 1/2", b_done, b_txn); end
    vectors++; if (b_last.x !== 32'h80000001) begin miscompares++; $display("FAIL wrap_last_rsp: got %h want 80000001", b_last.x); end
  endtask

  // Runs one full 4-transaction run on instance A. Response k==bad_k gets x+2.
  task automatic test_stream(input bit rand_sync, input int bad_k, input string tag);
    int k = 0;
    bit outst = 0;
    int errs = 0;
    int cyc = 0;
    bit req_x, rsp_x;
    compound_t rq, exp_last;
    logic signed [31:0] rx;
    exp_last = '0;
    @(negedge clk); a_start = 1; a_req_sync = 0; a_rsp_sync = 0;
    @(negedge clk); a_start = 0;
    while (k < NA && cyc < 400) begin
      cyc++;
      rq = exp_req(32'sd0, k);
      vectors++; if (a_req_notify !== !outst) begin miscompares++; $display("FAIL %s req_notify c%0d: got %b want %b", tag, cyc, a_req_notify, !outst); end
      vectors++; if (a_rsp_notify !== outst) begin miscompares++; $display("FAIL %s rsp_notify c%0d: got %b want %b", tag, cyc, a_rsp_notify, outst); end
      vectors++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin miscompares++; $display("FAIL %s busy_done c%0d: got %b%b want 10", tag, cyc, a_busy, a_done); end
      vectors++; if (a_txn !== 16'(k)) begin miscompares++; $display("FAIL %s txn_count c%0d: got %0d want %0d", tag, cyc, a_txn, k); end
      vectors++; if (a_err !== (CHK ? 16'(errs) : 16'd0)) begin miscompares++; $display("FAIL %s err_count c%0d: got %0d want %0d", tag, cyc, a_err, CHK ? errs : 0); end
      if (k > 0) begin
        vectors++; if (a_last !== exp_last) begin miscompares++; $display("FAIL %s last_rsp c%0d: got %h want %h", tag, cyc, a_last, exp_last); end
      end
      if (!outst) begin
        vectors++; if (a_req !== rq) begin miscompares++; $display("FAIL %s req_out c%0d: got %h want %h", tag, cyc, a_req, rq); end
      end
      a_req_sync = rand_sync ? 1'($urandom_range(0, 1)) : 1'b1;
      a_rsp_sync = rand_sync ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start    = rand_sync ? 1'($urandom_range(0, 1)) : 1'b0;
      if (outst) begin
        rx = rq.x + 32'sd1 + ((k == bad_k) ? 32'sd1 : 32'sd0);
        a_rsp = '{mode: rq.mode, x: rx, y: rx[0]};
      end else begin
        a_rsp = compound_t'({2'($urandom), $urandom});
      end
      req_x = !outst && a_req_sync;
      rsp_x = outst && a_rsp_sync;
      @(negedge clk);
      if (req_x) outst = 1;
      else if (rsp_x) begin
        exp_last = a_rsp;
        if (k == bad_k) errs++;
        k++;
        outst = 0;
      end
    end
    a_start = 0; a_req_sync = 1; a_rsp_sync = 1;
    if (!rand_sync) begin
      vectors++; if (cyc !== 2 * NA) begin miscompares++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc, 2 * NA); end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_req_notify !== 1'b0 || a_rsp_notify !== 1'b0) begin miscompares++; $display("FAIL %s end_flags[%0d]: got %b%b%b%b want 1000", tag, i, a_done, a_busy, a_req_notify, a_rsp_notify); end
      vectors++; if (a_txn !== 16'(NA)) begin miscompares++; $display("FAIL %s end_txn[%0d]: got %0d want %0d", tag, i, a_txn, NA); end
      vectors++; if (a_err !== (CHK ? 16'(errs) : 16'd0)) begin miscompares++; $display("FAIL %s end_err[%0d]: got %0d want %0d", tag, i, a_err, CHK ? errs : 0); end
      vectors++; if (a_last !== exp_last) begin miscompares++; $display("FAIL %s end_last[%0d]: got %h want %h", tag, i, a_last, exp_last); end
      @(negedge clk);
    end
    a_req_sync = 0; a_rsp_sync = 0;
  endtask

  task automatic test_backpressure();
    compound_t rq;
    logic signed [31:0] rx;
    rq = exp_req(32'sd0, 0);
    @(negedge clk); a_start = 1; a_req_sync = 0; a_rsp_sync = 0;
    @(negedge clk); a_start = 0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (a_req_notify !== 1'b1 || a_req !== rq) begin miscompares++; $display("FAIL bp_hold[%0d]: got notify=%b req=%h want 1/%h", i, a_req_notify, a_req, rq); end
      @(negedge clk);
    end
    a_req_sync = 1;
    @(negedge clk);
    vectors++; if ({a_req_notify, a_rsp_notify} !== 2'b01) begin miscompares++; $display("FAIL bp_one_xfer: got %b want 01", {a_req_notify, a_rsp_notify}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({a_req_notify, a_txn} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL bp_no_second_req[%0d]: got notify=%b txn=%0d want 0/0", i, a_req_notify, a_txn); end
    end
    rx = rq.x + 32'sd1;
    a_rsp = '{mode: rq.mode, x: rx, y: rx[0]}; a_rsp_sync = 1;
    @(negedge clk);
    vectors++; if (a_txn !== 16'd1 || a_req !== exp_req(32'sd0, 1)) begin miscompares++; $display("FAIL bp_second_req: got txn=%0d req=%h want 1/%h", a_txn, a_req, exp_req(32'sd0, 1)); end
    for (int i = 0; i < 50 && !a_done; i++) begin
      a_rsp = '{mode: a_req.mode, x: a_req.x + 32'sd1, y: ~a_req.x[0]};
      @(negedge clk);
    end
    vectors++; if (a_done !== 1'b1 || a_txn !== 16'(NA)) begin miscompares++; $display("FAIL bp_finish: got done=%b txn=%0d want 1/%0d", a_done, a_txn, NA); end
    a_req_sync = 0; a_rsp_sync = 0;
  endtask

  task automatic test_reset_midrun();
    logic signed [31:0] rx;
    @(negedge clk); a_start = 1; a_req_sync = 1; a_rsp_sync = 1;
    rx = 32'sd1;
    a_rsp = '{mode: MODE_WRITE, x: rx, y: rx[0]};
    @(negedge clk); a_start = 0;
    repeat (3) @(negedge clk);
    vectors++; if (a_rsp_notify !== 1'b1 || a_txn !== 16'd1) begin miscompares++; $display("FAIL mid_setup: got rsp_notify=%b txn=%0d want 1/1", a_rsp_notify, a_txn); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({a_req, a_last} !== 68'h0) begin miscompares++; $display("FAIL mid_reset_payload: got %h/%h want 0/0", a_req, a_last); end
    vectors++; if ({a_req_notify, a_rsp_notify, a_busy, a_done, a_txn, a_err} !== 36'h0) begin miscompares++; $display("FAIL mid_reset_status: got %h want 0", {a_req_notify, a_rsp_notify, a_busy, a_done, a_txn, a_err}); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({a_req_notify, a_rsp_notify, a_busy, a_done, a_txn} !== 20'h0) begin miscompares++; $display("FAIL mid_idle[%0d]: got %h want 0", i, {a_req_notify, a_rsp_notify, a_busy, a_done, a_txn}); end
    end
    a_req_sync = 0; a_rsp_sync = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_num_txn_zero();
    test_wrap();
    test_stream(1'b0, -1, "loopback");
    test_stream(1'b0, 2, "corrupt3");
    for (int r = 0; r < 6; r++) test_stream(1'b1, int'($urandom_range(0, 4)), "random");
    test_backpressure();
    test_reset_midrun();
    test_stream(1'b0, -1, "restart");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/compound_peer.md
COMPOUND_PEER -- requirements
Module: compound_peer

Interface
REQ-001 SHALL have parameter NUM_TXN, default 16, number of request/response transactions per run (0..65535).
REQ-002 SHALL have parameter X_START, default 0, x value of the first request (32-bit signed).
REQ-003 SHALL have parameter X_OFFSET, default 1, expected difference rsp.x minus req.x (checker only).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin a run.
- req_out  out  CompoundType  request payload; fields mode (read/write), x (32-bit signed), y (1 bit).
- req_out_sync  in  1  consumer ready to accept req_out.
- req_out_notify  out  1  req_out valid/offered.
- rsp_in  in  CompoundType  response payload.
- rsp_in_sync  in  1  producer offering rsp_in.
- rsp_in_notify  out  1  ready to accept rsp_in.
- busy  out  1  run in progress.
- done  out  1  run complete.
- txn_count  out  16  completed transactions.
- err_count  out  16  response mismatches.
- last_rsp  out  CompoundType  most recently captured response.

Function
REQ-005 SHALL implement FSM states IDLE, SEND, WAIT_RSP, DONE.
REQ-006 Transfer rule, both ports: a transfer SHALL occur in exactly the cycles where notify and sync are both 1 at the rising edge; no transfer otherwise.
REQ-007 All notify outputs SHALL be registered: high in every cycle spent in the owning state, low from the cycle after the transfer.
REQ-008 IDLE or DONE, start=1 SHALL clear txn_count, err_count and done, load req_out to {mode=write, x=X_START, y=X_START[0]}, and go to SEND; if NUM_TXN=0, go directly to DONE instead.
REQ-009 SEND SHALL hold req_out stable and req_out_notify=1 until the transfer; on transfer, go to WAIT_RSP.
REQ-010 WAIT_RSP SHALL drive rsp_in_notify=1; on transfer, capture rsp_in into last_rsp and increment txn_count.
REQ-011 After a WAIT_RSP transfer, if the incremented txn_count equals NUM_TXN, go to DONE; otherwise go to SEND with x=x+1, mode toggled (write/read alternating), and y=new x[0].
REQ-012 Only one transaction SHALL be outstanding; rsp_in_sync outside WAIT_RSP SHALL be ignored.
REQ-013 x SHALL wrap two's-complement: 32'h7FFFFFFF+1 gives 32'h80000000, with no flag.
REQ-014 txn_count and err_count SHALL saturate at 16'hFFFF.
REQ-015 busy SHALL be 1 exactly in SEND and WAIT_RSP; done SHALL be 1 exactly in DONE.
REQ-016 start SHALL be ignored in SEND and WAIT_RSP.
REQ-017 req_out_sync=1 in WAIT_RSP SHALL NOT cause a second request.

Reset
REQ-018 While rst=0 (asynchronous), SHALL force: state IDLE, req_out={read,0,0}, req_out_notify=0, rsp_in_notify=0, busy=0, done=0, txn_count=0, err_count=0, last_rsp={read,0,0}.
REQ-019 Reset asserted mid-run SHALL abort the transaction with no partial transfer counted; after release, SHALL wait in IDLE for start.

Configuration
REQ-020 With macro COMPOUND_PEER_CHECK_EN defined, each WAIT_RSP transfer SHALL increment err_count when rsp_in.x != req.x+X_OFFSET (32-bit wrap), or rsp_in.mode != req.mode, or rsp_in.y != rsp_in.x[0].
REQ-021 Without COMPOUND_PEER_CHECK_EN, err_count SHALL be constant 0 and no comparison logic SHALL be present; all other behaviour is unchanged.

Verification
REQ-022 Loopback responder returning x+1, sync always 1, NUM_TXN=4 -> each transfer takes 1 cycle; 4 requests x=0..3 with modes write,read,write,read; done=1; txn_count=4; err_count=0.
REQ-023 req_out_sync held 0 for 5 cycles in SEND -> req_out stable and notify high for all 5 cycles; exactly one transfer when sync rises.
REQ-024 X_START=32'h7FFFFFFF, NUM_TXN=2 -> second request x=32'h80000000 with y=0.
REQ-025 CHECK_EN defined, responder returns x+2 on the 3rd transaction only -> err_count=1, txn_count=NUM_TXN; without CHECK_EN -> err_count=0.
REQ-026 rst pulled low during WAIT_RSP of transaction 2 -> all outputs at REQ-018 values immediately (before the next clock edge); new start restarts from X_START; start pulsed while busy -> no effect.
REQ-027 NUM_TXN=0, start pulse -> DONE the next cycle; no notify asserted; txn_count=0.
